// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start detection, oversampling edge/bit counting,
// checker strobes and a one-cycle clean/rejected verdict per frame.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [3:0]                bit_cnt,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      deser_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic                      frame_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE  = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] EDGE_TWO  = PRESCALE_WIDTH'(2);
    localparam logic [3:0]                LAST_DATA = 4'(DATA_WIDTH);

    state_t                      state_q, state_d;
    logic [PRESCALE_WIDTH-1:0]   edge_q, edge_d;
    logic [PRESCALE_WIDTH-1:0]   p_q, p_d;
    logic [3:0]                  bit_q, bit_d;
    logic                        pe_q, pe_d;
    logic                        perr_q, perr_d;
    logic                        serr_q, serr_d;
    logic                        last_edge;
    logic                        chk_edge;
    logic                        clean;

    assign last_edge = (edge_q == p_q - EDGE_ONE);
    assign chk_edge  = (edge_q == p_q - EDGE_TWO);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= '0;
            pe_q    <= 1'b0;
            perr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            pe_q    <= pe_d;
            perr_q  <= perr_d;
            serr_q  <= serr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        bit_d   = bit_q;
        p_d     = p_q;
        pe_d    = pe_q;
        perr_d  = perr_q;
        serr_d  = serr_q;

        if (state_q != IDLE) begin
            edge_d = last_edge ? '0 : edge_q + EDGE_ONE;
            if (last_edge) begin
                bit_d = bit_q + 4'd1;
            end
        end

        case (state_q)
            IDLE, ERR_CHK: begin
                // The detection cycle is edge 0, so START begins at edge 1.
                if (!RX_IN) begin
                    state_d = START;
                    edge_d  = EDGE_ONE;
                    bit_d   = '0;
                    p_d     = Prescale;
                    pe_d    = PAR_EN;
                    perr_d  = 1'b0;
                    serr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (last_edge) begin
                    if (strt_glitch) begin
                        state_d = IDLE;
                        edge_d  = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_edge && (bit_q == LAST_DATA)) begin
                    state_d = pe_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d = STOP;
                    perr_d  = par_err;
                end
            end
            STOP: begin
                // Checker results are only valid at P-1, so hold them for the verdict.
                if (last_edge) begin
                    state_d = ERR_CHK;
                    serr_d  = stp_err;
                    bit_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign clean       = !serr_q && !(pe_q && perr_q);
    assign edge_cnt    = edge_q;
    assign bit_cnt     = bit_q;
    assign dat_samp_en = (state_q == START) || (state_q == DATA) ||
                         (state_q == PARITY) || (state_q == STOP);
    assign strt_chk_en = (state_q == START)  && chk_edge;
    assign deser_en    = (state_q == DATA)   && chk_edge;
    assign par_chk_en  = (state_q == PARITY) && chk_edge;
    assign stp_chk_en  = (state_q == STOP)   && chk_edge;
    assign data_valid  = (state_q == ERR_CHK) && clean;
    assign frame_err   = (state_q == ERR_CHK) && !clean;

endmodule
